// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: issues reset (0xFF) and LED (0xED + arg) commands,
// handles ACK/RESEND/timeout with bounded retries, and passes idle scancodes through.
module ps2_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       cmd_trig,
  output logic [7:0] cmd,
  input  logic [7:0] scancode,
  input  logic       scan_ready,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_BAT, FAIL} state_t;

  state_t        state, state_nxt;
  logic          phase, phase_nxt;  // 0: command byte, 1: argument byte
  logic [7:0]    cur_byte, cur_byte_nxt;
  logic [7:0]    arg_byte, arg_byte_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [TW-1:0] timer;
  logic          pend_init, pend_led;
  logic [2:0]    pend_led_val;
  logic          accept_init, accept_led, seq_ok, seq_fail, timeout;
  logic          rx_ack, rx_nak, rx_bat, rx_bat_err;

  assign timeout    = (timer == T_LAST);
  assign rx_ack     = scan_ready && (scancode == 8'hFA);
  assign rx_nak     = scan_ready && (scancode == 8'hFE);
  assign rx_bat     = scan_ready && (scancode == 8'hAA);
  assign rx_bat_err = scan_ready && (scancode == 8'hFC);

  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      phase        <= 1'b0;
      cur_byte     <= 8'h00;
      arg_byte     <= 8'h00;
      retry        <= '0;
      timer        <= '0;
      pend_init    <= 1'b0;
      pend_led     <= 1'b0;
      pend_led_val <= 3'b000;
      done         <= 1'b0;
      error        <= 1'b0;
      key_valid    <= 1'b0;
      key_code     <= 8'h00;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      cur_byte <= cur_byte_nxt;
      arg_byte <= arg_byte_nxt;
      retry    <= retry_nxt;
      // Timer restarts on any state change, so each resend gets a full window
      if (state_nxt != state)                         timer <= '0;
      else if (state == WAIT_ACK || state == WAIT_BAT) timer <= timer + TW'(1);
      else                                            timer <= '0;
      pend_init <= !accept_init && (pend_init || init_req);
      pend_led  <= !accept_led && (pend_led || led_req);
      if (led_req) pend_led_val <= led_val;
      done <= seq_ok;
      if (seq_fail)                                   error <= 1'b1;
      else if (seq_ok || accept_init || accept_led)   error <= 1'b0;
      key_valid <= (state == IDLE) && scan_ready;
      if ((state == IDLE) && scan_ready) key_code <= scancode;
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    cur_byte_nxt = cur_byte;
    arg_byte_nxt = arg_byte;
    retry_nxt    = retry;
    accept_init  = 1'b0;
    accept_led   = 1'b0;
    seq_ok       = 1'b0;
    seq_fail     = 1'b0;
    case (state)
      IDLE: begin
        if (init_req || pend_init) begin
          accept_init  = 1'b1;
          cur_byte_nxt = 8'hFF;
          retry_nxt    = '0;
          state_nxt    = SEND;
        end else if (led_req || pend_led) begin
          accept_led   = 1'b1;
          cur_byte_nxt = 8'hED;
          arg_byte_nxt = {5'b00000, (led_req ? led_val : pend_led_val)};
          retry_nxt    = '0;
          state_nxt    = SEND;
        end
      end
      SEND: state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (rx_ack) begin
          retry_nxt = '0;
          if (phase) begin
            seq_ok    = 1'b1;
            state_nxt = IDLE;
          end else if (cur_byte == 8'hFF) begin
            state_nxt = WAIT_BAT;
          end else begin
            phase_nxt    = 1'b1;
            cur_byte_nxt = arg_byte;
            state_nxt    = SEND;
          end
        end else if (rx_nak || timeout) begin
          if (retry == R_MAX) begin
            seq_fail  = 1'b1;
            state_nxt = FAIL;
          end else begin
            retry_nxt = retry + RW'(1);
            state_nxt = SEND;
          end
        end
      end
      WAIT_BAT: begin
        if (rx_bat) begin
          seq_ok    = 1'b1;
          state_nxt = IDLE;
        end else if (rx_bat_err || timeout) begin
          seq_fail  = 1'b1;
          state_nxt = FAIL;
        end
      end
      FAIL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == IDLE) phase_nxt = 1'b0;
  end

  always_comb begin
    cmd_trig = (state == SEND);
    cmd      = cur_byte;
    busy     = (state != IDLE) || pend_init || pend_led;
  end
endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor
// pops and compares each cmd_trig / key_valid / done / error-rise it observes.
module tb_ps2_cmd_sequencer;
  localparam int K_CMD = 0, K_KEY = 1, K_DONE = 2, K_ERR = 3;

  logic       CLK50MHZ = 1'b0;
  logic       RST = 1'b1;
  logic       init_req = 1'b0, led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic [7:0] scancode = 8'h00;
  logic       scan_ready = 1'b0;
  logic       cmd_trig, key_valid, busy, done, error;
  logic [7:0] cmd, key_code;

  ps2_cmd_sequencer #(.TIMEOUT_CYCLES(100), .MAX_RETRY(3)) dut (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .init_req(init_req), .led_req(led_req),
    .led_val(led_val), .cmd_trig(cmd_trig), .cmd(cmd), .scancode(scancode),
    .scan_ready(scan_ready), .key_code(key_code), .key_valid(key_valid),
    .busy(busy), .done(done), .error(error)
  );

  always #5 CLK50MHZ = ~CLK50MHZ;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_kind[$];
  logic [7:0] exp_data[$];
  logic err_q = 1'b0;

  always @(posedge CLK50MHZ) cyc <= cyc + 1;

  task automatic push(input int kind, input logic [7:0] data);
    exp_kind.push_back(kind);
    exp_data.push_back(data);
  endtask

  task automatic chk_ev(input int kind, input logic [7:0] data);
    int ek;
    logic [7:0] ed;
    n_checks++;
    if (exp_kind.size() == 0) begin
      n_err++;
      $display("FAIL event: got kind=%0d data=%h at cycle %0d, none expected", kind, data, cyc);
    end else begin
      ek = exp_kind.pop_front();
      ed = exp_data.pop_front();
      if (ek != kind || ed !== data) begin
        n_err++;
        $display("FAIL event: got kind=%0d data=%h, expected kind=%0d data=%h (cycle %0d)",
                 kind, data, ek, ed, cyc);
      end
    end
  endtask

  always @(negedge CLK50MHZ) begin
    if (cmd_trig)        chk_ev(K_CMD, cmd);
    if (key_valid)       chk_ev(K_KEY, key_code);
    if (done)            chk_ev(K_DONE, 8'h00);
    if (error && !err_q) chk_ev(K_ERR, 8'h00);
    err_q = error;
  end

  task automatic tick();
    @(posedge CLK50MHZ);
    #1;
  endtask

  task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    scancode = b;
    scan_ready = 1'b1;
    tick();
    scan_ready = 1'b0;
  endtask

  task automatic drain(input string nm, input int maxc);
    for (int k = 0; k < maxc && exp_kind.size() > 0; k++) tick();
    if (exp_kind.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: %0d expected events never seen (next kind=%0d)", nm, exp_kind.size(), exp_kind[0]);
      exp_kind.delete();
      exp_data.delete();
    end
  endtask

  task automatic wait_trig(output int t);
    int k;
    k = 0;
    while (!cmd_trig && k < 300) begin
      tick();
      k++;
    end
    if (!cmd_trig) begin
      n_checks++;
      n_err++;
      $display("FAIL trig_wait: got no cmd_trig, required one within 300 cycles");
    end
    t = cyc;
    tick();
  endtask

  initial begin
    int t[4];
    int k;
    // reset values
    repeat (3) tick();
    check8("rst_outs", {cmd_trig, key_valid, busy, done, error, 3'b000}, 8'h00);
    check8("rst_cmd", cmd, 8'h00);
    check8("rst_key", key_code, 8'h00);
    RST = 1'b0;
    tick();

    // init path
    push(K_CMD, 8'hFF);
    init_req = 1'b1; tick(); init_req = 1'b0;
    check8("init_busy", {7'b0, busy}, 8'h01);
    tick();
    send_byte(8'hFA);
    push(K_DONE, 8'h00);
    send_byte(8'hAA);
    check8("init_busy_fall", {7'b0, busy}, 8'h00);
    check8("init_err", {7'b0, error}, 8'h00);
    drain("init", 20);

    // pass-through in idle
    push(K_KEY, 8'h1C);
    send_byte(8'h1C);
    drain("key_idle", 5);

    // LED path, with a stray byte while busy
    led_val = 3'b101;
    push(K_CMD, 8'hED);
    led_req = 1'b1; tick(); led_req = 1'b0;
    tick();
    push(K_CMD, 8'h05);
    send_byte(8'hFA);
    tick();
    send_byte(8'h1C);
    check8("busy_key_drop", {7'b0, key_valid}, 8'h00);
    push(K_DONE, 8'h00);
    send_byte(8'hFA);
    drain("led", 20);

    // resend until failure
    for (int i = 0; i < 4; i++) push(K_CMD, 8'hFF);
    push(K_ERR, 8'h00);
    init_req = 1'b1; tick(); init_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hFE);
      if (i < 3) tick();
    end
    check8("nak_err", {7'b0, error}, 8'h01);
    tick();
    check8("nak_idle", {7'b0, busy}, 8'h00);
    drain("nak", 10);

    // timeout path
    for (int i = 0; i < 4; i++) push(K_CMD, 8'hFF);
    push(K_ERR, 8'h00);
    init_req = 1'b1; tick(); init_req = 1'b0;
    check8("accept_clr_err", {7'b0, error}, 8'h00);
    for (int i = 0; i < 4; i++) wait_trig(t[i]);
    for (int i = 1; i < 4; i++) check8($sformatf("to_gap%0d", i), 8'(t[i] - t[i-1]), 8'd101);
    k = 0;
    while (!error && k < 200) begin tick(); k++; end
    check8("to_err", {7'b0, error}, 8'h01);
    tick();
    check8("to_idle", {7'b0, busy}, 8'h00);
    drain("timeout", 10);

    // pending LED during init; second led_req overwrites value
    push(K_CMD, 8'hFF);
    init_req = 1'b1; tick(); init_req = 1'b0;
    led_req = 1'b1; led_val = 3'b010; tick();
    led_val = 3'b011; tick();
    led_req = 1'b0;
    send_byte(8'hFA);
    push(K_DONE, 8'h00);
    push(K_CMD, 8'hED);
    send_byte(8'hAA);
    check8("pend_busy", {7'b0, busy}, 8'h01);
    tick();
    tick();
    push(K_CMD, 8'h03);
    send_byte(8'hFA);
    tick();
    push(K_DONE, 8'h00);
    send_byte(8'hFA);
    drain("pend", 20);

    // reset in WAIT_ACK
    push(K_CMD, 8'hFF);
    init_req = 1'b1; tick(); init_req = 1'b0;
    tick();
    drain("rst_seq", 5);
    RST = 1'b1;
    scancode = 8'hFA; scan_ready = 1'b1;
    #1;
    check8("arst_outs", {cmd_trig, key_valid, busy, done, error, 3'b000}, 8'h00);
    check8("arst_cmd", cmd, 8'h00);
    check8("arst_key", key_code, 8'h00);
    tick(); tick();
    scan_ready = 1'b0;
    RST = 1'b0;
    repeat (10) tick();
    check8("post_rst_busy", {7'b0, busy}, 8'h00);
    drain("end", 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
